// File: rtl/host_cmd_decoder_pkg.sv
// Shared constants and types for the host command decoder:
// tag words, command codes, default header/EtherType, FSM states.
package host_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    CMD_TRIG = 2'd0,
    CMD_SLOW = 2'd1,
    CMD_RATE = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_code_e;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } dec_state_e;

  typedef struct packed {
    logic      hit;
    cmd_code_e code;
  } tag_hit_t;

  // ASCII tags, first received byte in the low byte
  localparam logic [47:0] TAG_TRIG = 48'h6E69_6769_7274;
  localparam logic [47:0] TAG_SLOW = 48'h656D_776F_6C73;
  localparam logic [47:0] TAG_RATE = 48'h6E69_6574_6172;

  localparam logic [95:0] HDR_MATCH_DEF =
    96'h8F54_0000_1654_4502_1111_6843;
  localparam logic [15:0] ETH_TYPE_DEF = 16'h005C;

  function automatic tag_hit_t tag_lookup(
    input logic [47:0] tag
  );
    tag_hit_t r;
    r.hit  = 1'b1;
    r.code = CMD_TRIG;
    unique case (1'b1)
      tag == TAG_TRIG: r.code = CMD_TRIG;
      tag == TAG_SLOW: r.code = CMD_SLOW;
      tag == TAG_RATE: r.code = CMD_RATE;
      default:         r.hit  = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/host_cmd_decoder_hdrcmp.sv
// Single-beat compare of a data word (under a bit mask) and its byte keep.
// Ports: data, strb, exp_word, exp_mask in; match, strb_ok out.
module hdrcmp (
  input  logic [31:0] data,
  input  logic [3:0]  strb,
  input  logic [31:0] exp_word,
  input  logic [31:0] exp_mask,
  output logic        match,
  output logic        strb_ok
);

  assign match   = ((data ^ exp_word) & exp_mask) == 32'h0;
  assign strb_ok = strb == 4'hF;

endmodule

// File: rtl/host_cmd_decoder.sv
// Decodes host command frames from the MAC AXI-stream (no backpressure).
// Ports: clk, reset; RvviAxiR{data,strb,valid,last} in;
// CmdValid, CmdCode, CmdPayload, FrameErr, GoodCount, DropCount out.
module host_cmd_decoder
  import host_cmd_decoder_pkg::*;
#(
  parameter int HEADER_WORDS = 3,
  parameter logic [32*HEADER_WORDS-1:0] HDR_MATCH = HDR_MATCH_DEF,
  parameter logic [15:0] ETH_TYPE = ETH_TYPE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RvviAxiRdata,
  input  logic [3:0]  RvviAxiRstrb,
  input  logic        RvviAxiRvalid,
  input  logic        RvviAxiRlast,
  output logic        CmdValid,
  output logic [1:0]  CmdCode,
  output logic [31:0] CmdPayload,
  output logic        FrameErr,
  output logic [15:0] GoodCount,
  output logic [15:0] DropCount
);

  localparam int IW = $clog2(HEADER_WORDS + 3);
  localparam logic [IW-1:0] TYPE_IDX = IW'(HEADER_WORDS);
  localparam logic [IW-1:0] TAG_IDX  = IW'(HEADER_WORDS + 1);
  localparam logic [IW-1:0] PAY_IDX  = IW'(HEADER_WORDS + 2);

  dec_state_e    state;
  logic [IW-1:0] idx;
  logic          drop_pend;
  logic [15:0]   tag_lo;
  cmd_code_e     code_stage;
  logic [31:0]   pay_stage;

  logic [31:0] exp_word;
  logic [31:0] exp_mask;
  logic        match;
  logic        strb_ok;
  tag_hit_t    hit;
  logic        hdr_ok;
  logic        accept;
  logic        frame_err;
  logic        beat_bad;
  logic        drop_now;

  always_comb begin
    exp_word = 32'h0;
    exp_mask = 32'h0;
    if (idx < TYPE_IDX) begin
      exp_word = HDR_MATCH[32*int'(idx) +: 32];
      exp_mask = 32'hFFFF_FFFF;
    end else if (idx == TYPE_IDX) begin
      exp_word = {16'h0, ETH_TYPE};
      exp_mask = 32'h0000_FFFF;
    end
  end

  hdrcmp u_cmp (
    .data     (RvviAxiRdata),
    .strb     (RvviAxiRstrb),
    .exp_word (exp_word),
    .exp_mask (exp_mask),
    .match    (match),
    .strb_ok  (strb_ok)
  );

  assign hit    = tag_lookup({RvviAxiRdata, tag_lo});
  assign hdr_ok = match && !(idx == TAG_IDX && !hit.hit);

  // Strobe failure outranks a mismatch, which outranks a short frame.
  // Quiet drops (mismatch/unknown tag) count on the frame's last beat.
  always_comb begin
    accept    = 1'b0;
    frame_err = 1'b0;
    beat_bad  = 1'b0;
    drop_now  = 1'b0;
    if (RvviAxiRvalid) begin
      unique case (state)
        S_HDR: begin
          if (!strb_ok) begin
            frame_err = 1'b1;
          end else if (!hdr_ok) begin
            beat_bad = 1'b1;
            drop_now = RvviAxiRlast;
          end else if (RvviAxiRlast) begin
            accept    = idx == PAY_IDX;
            frame_err = idx != PAY_IDX;
          end
        end
        S_DONE:  accept   = RvviAxiRlast;
        S_DRAIN: drop_now = RvviAxiRlast && drop_pend;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HDR;
      idx        <= '0;
      drop_pend  <= 1'b0;
      tag_lo     <= 16'h0;
      code_stage <= CMD_TRIG;
      pay_stage  <= 32'h0;
      CmdValid   <= 1'b0;
      CmdCode    <= 2'd0;
      CmdPayload <= 32'h0;
      FrameErr   <= 1'b0;
      GoodCount  <= 16'h0;
      DropCount  <= 16'h0;
    end else begin
      CmdValid <= 1'b0;
      FrameErr <= frame_err;
      if (accept) begin
        CmdValid   <= 1'b1;
        CmdCode    <= code_stage;
        // a command ending on the payload beat has not staged it yet
        CmdPayload <= (state == S_HDR) ? RvviAxiRdata : pay_stage;
        GoodCount  <= sat_inc(GoodCount);
      end
      if (frame_err || drop_now)
        DropCount <= sat_inc(DropCount);
      if (RvviAxiRvalid) begin
        if (state == S_HDR) begin
          if (idx == TYPE_IDX) tag_lo <= RvviAxiRdata[31:16];
          if (idx == TAG_IDX) code_stage <= hit.code;
          if (idx == PAY_IDX) pay_stage <= RvviAxiRdata;
        end
        if (RvviAxiRlast) begin
          state     <= S_HDR;
          idx       <= '0;
          drop_pend <= 1'b0;
        end else if (frame_err || beat_bad) begin
          state     <= S_DRAIN;
          drop_pend <= beat_bad;
        end else if (state == S_HDR) begin
          if (idx == PAY_IDX) state <= S_DONE;
          else idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Scoreboard bench for host_cmd_decoder: frame-level reference model,
// randomized frames, directed corner cases, counter saturation, reset.
module tb_host_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RvviAxiRdata;
  logic [3:0]  RvviAxiRstrb;
  logic        RvviAxiRvalid;
  logic        RvviAxiRlast;
  logic        CmdValid;
  logic [1:0]  CmdCode;
  logic [31:0] CmdPayload;
  logic        FrameErr;
  logic [15:0] GoodCount;
  logic [15:0] DropCount;

  always #5 clk = ~clk;

  host_cmd_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .RvviAxiRdata  (RvviAxiRdata),
    .RvviAxiRstrb  (RvviAxiRstrb),
    .RvviAxiRvalid (RvviAxiRvalid),
    .RvviAxiRlast  (RvviAxiRlast),
    .CmdValid      (CmdValid),
    .CmdCode       (CmdCode),
    .CmdPayload    (CmdPayload),
    .FrameErr      (FrameErr),
    .GoodCount     (GoodCount),
    .DropCount     (DropCount)
  );

  localparam int K_CMD  = 0;
  localparam int K_ERR  = 1;
  localparam int K_DROP = 2;

  typedef struct {
    int          kind;
    logic [1:0]  code;
    logic [31:0] pay;
    logic [15:0] good;
    logic [15:0] drop;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0] hdr_all = 96'h8F54_0000_1654_4502_1111_6843;
  logic [31:0] fd[16];
  logic [3:0]  fs[16];
  int          flen;

  int          m_good = 0;
  int          m_drop = 0;
  logic [1:0]  m_code = 2'd0;
  logic [31:0] m_pay  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [47:0] ascii_tag(input string s);
    logic [47:0] t;
    t = '0;
    for (int i = 0; i < 6; i++) t[8*i +: 8] = s[i];
    return t;
  endfunction

  function automatic int tag_code(input logic [47:0] t);
    if (t == ascii_tag("trigin")) return 0;
    if (t == ascii_tag("slowme")) return 1;
    if (t == ascii_tag("ratein")) return 2;
    return -1;
  endfunction

  // Outcome of the whole frame held in fd/fs/flen
  function automatic int eval_frame(output int code);
    code = -1;
    for (int k = 0; k < flen; k++) begin
      if (k < 6 && fs[k] != 4'hF) return K_ERR;
      if (k < 3 && fd[k] != hdr_all[32*k +: 32]) return K_DROP;
      if (k == 3 && fd[3][15:0] != 16'h005C) return K_DROP;
      if (k == 4) begin
        code = tag_code({fd[4], fd[3][31:16]});
        if (code < 0) return K_DROP;
      end
      if (k == flen - 1) return (k >= 5) ? K_CMD : K_ERR;
    end
    return K_ERR;
  endfunction

  task automatic model_push();
    int   kind;
    int   code;
    exp_t e;
    kind = eval_frame(code);
    if (kind == K_CMD) begin
      if (m_good < 65535) m_good++;
      m_code = 2'(code);
      m_pay  = fd[5];
    end else begin
      // a quiet drop at saturation leaves nothing to observe
      if (kind == K_DROP && m_drop == 65535) return;
      if (m_drop < 65535) m_drop++;
    end
    e.kind = kind;
    e.code = m_code;
    e.pay  = m_pay;
    e.good = 16'(m_good);
    e.drop = 16'(m_drop);
    q.push_back(e);
  endtask

  task automatic make_frame(input string tg, input logic [31:0] pay,
                            input int len);
    logic [47:0] t;
    t = ascii_tag(tg);
    for (int k = 0; k < 16; k++) begin
      fd[k] = $urandom;
      fs[k] = 4'hF;
    end
    for (int k = 0; k < 3; k++) fd[k] = hdr_all[32*k +: 32];
    fd[3] = {t[15:0], 16'h005C};
    fd[4] = t[47:16];
    fd[5] = pay;
    flen  = len;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    RvviAxiRvalid = 1'b0;
    RvviAxiRdata  = $urandom;
    RvviAxiRstrb  = 4'($urandom);
    RvviAxiRlast  = 1'($urandom);
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s,
                      input logic l);
    @(posedge clk);
    #1;
    RvviAxiRvalid = 1'b1;
    RvviAxiRdata  = d;
    RvviAxiRstrb  = s;
    RvviAxiRlast  = l;
  endtask

  task automatic send(input int gmin, input int gmax);
    model_push();
    for (int k = 0; k < flen; k++) begin
      repeat ($urandom_range(gmax, gmin)) idle();
      beat(fd[k], fs[k], k == flen - 1);
    end
  endtask

  // Monitor: any pulse or counter movement is one frame outcome
  initial begin
    logic [15:0] pg;
    logic [15:0] pd;
    exp_t        e;
    pg = 16'h0;
    pd = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pg = 16'h0;
        pd = 16'h0;
      end else if (CmdValid || FrameErr || GoodCount != pg
                   || DropCount != pd) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: CmdValid=%b FrameErr=%b good=%h drop=%h",
                   CmdValid, FrameErr, GoodCount, DropCount);
        end else begin
          e = q.pop_front();
          chk("cmd_valid", 32'(CmdValid), 32'(e.kind == K_CMD));
          chk("frame_err", 32'(FrameErr), 32'(e.kind == K_ERR));
          chk("cmd_code", 32'(CmdCode), 32'(e.code));
          chk("cmd_payload", CmdPayload, e.pay);
          chk("good_count", 32'(GoodCount), 32'(e.good));
          chk("drop_count", 32'(DropCount), 32'(e.drop));
        end
        pg = GoodCount;
        pd = DropCount;
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 32'(CmdValid), 32'h0);
    chk({nm, "_code"}, 32'(CmdCode), 32'h0);
    chk({nm, "_payload"}, CmdPayload, 32'h0);
    chk({nm, "_ferr"}, 32'(FrameErr), 32'h0);
    chk({nm, "_good"}, 32'(GoodCount), 32'h0);
    chk({nm, "_drop"}, 32'(DropCount), 32'h0);
  endtask

  initial begin
    string tags[3];
    int    r;
    tags[0] = "trigin";
    tags[1] = "slowme";
    tags[2] = "ratein";

    reset         = 1'b1;
    RvviAxiRvalid = 1'b0;
    RvviAxiRdata  = 32'h0;
    RvviAxiRstrb  = 4'h0;
    RvviAxiRlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    make_frame("trigin", 32'h0, 6);
    send(0, 0);
    make_frame("ratein", 32'h10, 6);
    send(3, 3);
    make_frame("trigin", 32'h1234, 8);
    fd[0] = 32'h1111_6844;
    send(0, 1);
    make_frame("slowme", 32'h7, 7);
    send(0, 1);
    make_frame("trigin", 32'h1, 4);
    send(0, 0);
    make_frame("trigin", 32'h2, 6);
    fs[5] = 4'h7;
    send(0, 0);
    make_frame("slowme", 32'hA, 6);
    send(0, 0);
    make_frame("slowme", 32'hB, 6);
    send(0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(9, 0);
      make_frame((r == 0) ? "xyzzy!" : tags[$urandom_range(2, 0)],
                 $urandom,
                 (r == 1) ? $urandom_range(5, 1) : $urandom_range(9, 6));
      if (r == 2) fd[$urandom_range(3, 0)] ^= 32'h1 << $urandom_range(31, 0);
      if (r == 3) fs[$urandom_range(7, 0)] = 4'($urandom_range(14, 0));
      send(0, 2);
    end

    while (m_drop < 65534) begin
      make_frame("trigin", 32'h0, 1);
      fd[0] = 32'h1111_6844;
      send(0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      make_frame("trigin", 32'h0, 6);
      fd[1] = 32'h0;
      send(0, 0);
    end
    repeat (5) idle();
    chk("drop_saturated", 32'(DropCount), 32'hFFFF);
    chk("queue_drained", 32'(q.size()), 32'h0);

    make_frame("trigin", 32'h55, 6);
    beat(fd[0], fs[0], 1'b0);
    beat(fd[1], fs[1], 1'b0);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    RvviAxiRvalid = 1'b1;
    RvviAxiRdata  = fd[2];
    RvviAxiRstrb  = 4'hF;
    RvviAxiRlast  = 1'b0;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    RvviAxiRvalid = 1'b0;
    chk_zero("midreset");
    m_good = 0;
    m_drop = 0;
    m_code = 2'd0;
    m_pay  = 32'h0;
    for (int k = 0; k < 3; k++) fd[k] = fd[k+3];
    flen = 3;
    send(0, 0);
    make_frame("ratein", 32'hCAFE, 6);
    send(0, 1);
    repeat (5) idle();
    chk("final_queue", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
